// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: column sweep, frame-level debounce,
// one event per press, and a 4-digit shift-in entry buffer.
module keypad_scan4x4 #(
    parameter int NBITS_COMPARE   = 26,
    parameter int COMPARE         = 100_000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic       clr,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [4:0] disp0,
    output logic [4:0] disp1,
    output logic [4:0] disp2,
    output logic [4:0] disp3
);

    localparam logic [NBITS_COMPARE-1:0] LAST = NBITS_COMPARE'(COMPARE - 1);
    localparam logic [3:0] NFR = 4'(DEBOUNCE_FRAMES);
    // nibble {col,row} holds the hex legend of that key
    localparam logic [63:0] KMAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    logic [3:0]               rs1, rs2;
    logic [NBITS_COMPARE-1:0] dwell;
    logic [1:0]               col_idx;
    logic                     dwell_end;
    logic                     hit;
    logic [1:0]               rsel;
    logic [3:0]               code;
    logic                     f_any;
    logic [3:0]               f_key;
    logic                     acc_any;
    logic [3:0]               acc_key;
    logic                     ev;
    logic                     fr_any;
    logic [3:0]               fr_key;
    state_t                   state, nstate;
    logic [3:0]               cnt, ncnt;
    logic [3:0]               cand, ncand;
    logic                     accept;

    assign col       = ~(4'b0001 << col_idx);
    assign dwell_end = (dwell == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1 <= 4'b1111;
            rs2 <= 4'b1111;
        end else begin
            rs1 <= row;
            rs2 <= rs1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (dwell_end) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + NBITS_COMPARE'(1);
        end
    end

    // lowest pressed row in the active column wins
    always_comb begin
        hit  = 1'b0;
        rsel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs2[i]) begin
                hit  = 1'b1;
                rsel = 2'(i);
            end
        end
    end

    assign code  = KMAP[{col_idx, rsel, 2'b00} +: 4];
    assign f_any = (col_idx == 2'd0) ? hit : (acc_any | hit);
    assign f_key = (col_idx != 2'd0 && acc_any) ? acc_key : code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_any <= 1'b0;
            acc_key <= 4'h0;
            fr_any  <= 1'b0;
            fr_key  <= 4'h0;
            ev      <= 1'b0;
        end else begin
            ev <= dwell_end && (col_idx == 2'd3);
            if (dwell_end) begin
                acc_any <= f_any;
                acc_key <= f_key;
                if (col_idx == 2'd3) begin
                    fr_any <= f_any;
                    fr_key <= f_key;
                end
            end
        end
    end

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        ncand  = cand;
        accept = 1'b0;
        if (ev) begin
            case (state)
                IDLE: begin
                    if (fr_any) begin
                        ncand = fr_key;
                        ncnt  = 4'd1;
                        if (NFR == 4'd1) begin
                            accept = 1'b1;
                            nstate = HELD;
                        end else begin
                            nstate = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!fr_any) begin
                        nstate = IDLE;
                    end else if (fr_key == cand) begin
                        ncnt = cnt + 4'd1;
                        if (ncnt == NFR) begin
                            accept = 1'b1;
                            nstate = HELD;
                        end
                    end else begin
                        ncand = fr_key;
                        ncnt  = 4'd1;
                    end
                end
                HELD: begin
                    if (!fr_any) begin
                        ncnt   = 4'd1;
                        nstate = (NFR == 4'd1) ? IDLE : RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (fr_any) begin
                        nstate = HELD;
                    end else begin
                        ncnt = cnt + 4'd1;
                        if (ncnt == NFR) nstate = IDLE;
                    end
                end
                default: nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'h0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            cand      <= ncand;
            key_valid <= accept;
            if (accept) key_code <= ncand;
        end
    end

    // clear beats a coincident accept; the event itself still fires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp0 <= 5'd0;
            disp1 <= 5'd0;
            disp2 <= 5'd0;
            disp3 <= 5'd0;
        end else if (clr) begin
            disp0 <= 5'd0;
            disp1 <= 5'd0;
            disp2 <= 5'd0;
            disp3 <= 5'd0;
        end else if (accept) begin
            disp3 <= disp2;
            disp2 <= disp1;
            disp1 <= disp0;
            disp0 <= {1'b1, ncand};
        end
    end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Bench for keypad_scan4x4: keypad emulation driven from a pressed-key
// mask, with a frame-level reference model of debounce and entry buffer.
module tb_keypad_scan4x4;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [4:0] disp0, disp1, disp2, disp3;
    logic [15:0] pressed = 16'h0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int evq[$];
    int evt[$];
    int expq[$];
    int kmap[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};
    int ms, mcand, mcnt;
    int mdisp[4];

    keypad_scan4x4 #(
        .NBITS_COMPARE(26),
        .COMPARE(4),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .clr(clr),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .disp0(disp0),
        .disp1(disp1),
        .disp2(disp2),
        .disp3(disp3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bit c*4+r of pressed closes the switch between column c and row r
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst && key_valid) begin
            evq.push_back(int'(key_code));
            evt.push_back(cyc);
        end
    end

    task automatic model_reset();
        ms = 0;
        mcand = 0;
        mcnt = 0;
        for (int i = 0; i < 4; i++) mdisp[i] = 0;
        expq.delete();
    endtask

    task automatic model_accept();
        expq.push_back(mcand);
        mdisp[3] = mdisp[2];
        mdisp[2] = mdisp[1];
        mdisp[1] = mdisp[0];
        mdisp[0] = 16 + mcand;
    endtask

    // one frame of the debounce rules; ms: 0 idle,1 press,2 held,3 release
    task automatic mstep(input logic [15:0] m);
        int k;
        k = -1;
        for (int i = 0; i < 16; i++)
            if (k < 0 && m[i]) k = kmap[i];
        case (ms)
            0: if (k >= 0) begin
                mcand = k;
                mcnt = 1;
                if (mcnt == DEB) begin model_accept(); ms = 2; end
                else ms = 1;
            end
            1: if (k < 0) ms = 0;
               else if (k == mcand) begin
                   mcnt++;
                   if (mcnt == DEB) begin model_accept(); ms = 2; end
               end else begin
                   mcand = k;
                   mcnt = 1;
               end
            2: if (k < 0) begin mcnt = 1; ms = (DEB == 1) ? 0 : 3; end
            default: if (k >= 0) ms = 2;
                     else begin mcnt++; if (mcnt >= DEB) ms = 0; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pressed = 16'h0;
        clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        evq.delete();
        evt.delete();
        rst = 1'b1;
    endtask

    // returns at the negedge of the first cycle of a frame (col0, count 0)
    task automatic sync_frame(output int t);
        logic [3:0] p;
        int n;
        p = col;
        n = 0;
        @(negedge clk);
        while (!(col == 4'b1110 && p == 4'b0111) && n < 64) begin
            p = col;
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL frame_sync timeout col=%b", col);
        end
        t = cyc;
    endtask

    task automatic frame(input logic [15:0] m, output int t);
        sync_frame(t);
        pressed = m;
        mstep(m);
    endtask

    task automatic test_reset();
        int t;
        logic [3:0] e;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (col !== 4'b1110 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out col=%b kv=%b want 1110/0", col, key_valid);
        end
        total++;
        if ({disp3, disp2, disp1, disp0} !== 20'h0) begin
            bad++;
            $display("FAIL reset_disp got=%h want 0", {disp3, disp2, disp1, disp0});
        end
        do_reset();
        sync_frame(t);
        for (int i = 0; i < 16; i++) begin
            e = ~(4'b0001 << (i / 4));
            total++;
            if (col !== e) begin
                bad++;
                $display("FAIL reset_sweep i=%0d col=%b want %b", i, col, e);
            end
            @(negedge clk);
        end
        frame(16'h0, t);
        frame(16'h0, t);
        total++;
        if (evq.size() != 0 || {disp3, disp2, disp1, disp0} !== 20'h0) begin
            bad++;
            $display("FAIL idle_quiet events=%0d want 0", evq.size());
        end
    endtask

    task automatic test_hold();
        int t, t1;
        do_reset();
        frame(16'h0020, t1);
        repeat (4) frame(16'h0020, t);
        repeat (3) frame(16'h0, t);
        total++;
        if (evq.size() != 1) begin
            bad++;
            $display("FAIL hold_count got=%0d want 1", evq.size());
        end else begin
            total++;
            if (evq[0] != 5) begin
                bad++;
                $display("FAIL hold_code got=%0d want 5", evq[0]);
            end
            total++;
            if (evt[0] != t1 + 49) begin
                bad++;
                $display("FAIL hold_time got=%0d want %0d", evt[0], t1 + 49);
            end
        end
        total++;
        if ({disp3, disp2, disp1, disp0} !== {5'h0, 5'h0, 5'h0, 5'h15}) begin
            bad++;
            $display("FAIL hold_disp got=%h want 00015", {disp3, disp2, disp1, disp0});
        end
    endtask

    task automatic test_change();
        int t;
        do_reset();
        repeat (2) frame(16'h0020, t);
        frame(16'h0, t);
        repeat (3) frame(16'h0400, t);
        repeat (3) frame(16'h0, t);
        total++;
        if (evq.size() != 1 || expq.size() != 1) begin
            bad++;
            $display("FAIL change_count got=%0d want 1", evq.size());
        end else begin
            total++;
            if (evq[0] != 9 || evq[0] != expq[0]) begin
                bad++;
                $display("FAIL change_code got=%0d want 9", evq[0]);
            end
        end
    endtask

    task automatic test_entry();
        int t;
        logic [15:0] seq[5] = '{16'h0001, 16'h0010, 16'h0100, 16'h0002, 16'h1000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            repeat (3) frame(seq[k], t);
            repeat (3) frame(16'h0, t);
        end
        frame(16'h0, t);
        total++;
        if (evq.size() != 5) begin
            bad++;
            $display("FAIL entry_count got=%0d want 5", evq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i] != expq[i]) begin
                bad++;
                $display("FAIL entry_code i=%0d got=%0d want %0d", i, evq[i], expq[i]);
            end
        end
        total++;
        if ({disp3, disp2, disp1, disp0} !== {5'h12, 5'h13, 5'h14, 5'h1A}) begin
            bad++;
            $display("FAIL entry_disp got=%h want 12,13,14,1A",
                     {disp3, disp2, disp1, disp0});
        end
    endtask

    task automatic test_bounce();
        int t;
        do_reset();
        repeat (4) frame(16'h0040, t);
        frame(16'h0, t);
        repeat (2) frame(16'h0040, t);
        repeat (3) frame(16'h0, t);
        repeat (3) frame(16'h0040, t);
        repeat (2) frame(16'h0, t);
        total++;
        if (evq.size() != 2 || expq.size() != 2) begin
            bad++;
            $display("FAIL bounce_count got=%0d want 2", evq.size());
        end else begin
            total++;
            if (evq[0] != 8 || evq[1] != 8) begin
                bad++;
                $display("FAIL bounce_code got=%0d,%0d want 8,8", evq[0], evq[1]);
            end
        end
    endtask

    task automatic test_clr();
        int t;
        do_reset();
        repeat (3) frame(16'h0004, t);
        repeat (3) frame(16'h0, t);
        total++;
        if (disp0 !== 5'h17) begin
            bad++;
            $display("FAIL clr_pre got=%h want 17", disp0);
        end
        repeat (4) frame(16'h8001, t);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) mdisp[i] = 0;
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h1) begin
            bad++;
            $display("FAIL clr_event kv=%b code=%h want 1/1", key_valid, key_code);
        end
        total++;
        if ({disp3, disp2, disp1, disp0} !== 20'h0) begin
            bad++;
            $display("FAIL clr_disp got=%h want 0", {disp3, disp2, disp1, disp0});
        end
        repeat (4) frame(16'h0, t);
        total++;
        if (evq.size() != 2 || expq.size() != 2) begin
            bad++;
            $display("FAIL clr_count got=%0d want 2", evq.size());
        end
    endtask

    task automatic test_midreset();
        int t;
        do_reset();
        repeat (2) frame(16'h0040, t);
        sync_frame(t);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        pressed = 16'h0;
        #1;
        total++;
        if (col !== 4'b1110 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_col got=%b want 1110", col);
        end
        @(negedge clk);
        model_reset();
        evq.delete();
        evt.delete();
        rst = 1'b1;
        repeat (2) frame(16'h0040, t);
        repeat (3) frame(16'h0, t);
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL midreset_progress events=%0d want 0", evq.size());
        end
        repeat (3) frame(16'h0040, t);
        repeat (2) frame(16'h0, t);
        total++;
        if (evq.size() != 1 || expq.size() != 1) begin
            bad++;
            $display("FAIL midreset_after events=%0d want 1", evq.size());
        end
    endtask

    task automatic test_random();
        int t, kind, len;
        logic [15:0] m;
        do_reset();
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 2);
            m = 16'h0;
            if (kind >= 1) m[$urandom_range(0, 15)] = 1'b1;
            if (kind == 2) m[$urandom_range(0, 15)] = 1'b1;
            len = $urandom_range(1, 4);
            repeat (len) frame(m, t);
        end
        repeat (4) frame(16'h0, t);
        total++;
        if (evq.size() != expq.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d want %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i] != expq[i]) begin
                bad++;
                $display("FAIL rand_code i=%0d got=%0d want %0d", i, evq[i], expq[i]);
            end
        end
        total++;
        if ({disp3, disp2, disp1, disp0} !== {5'(mdisp[3]), 5'(mdisp[2]),
                                              5'(mdisp[1]), 5'(mdisp[0])}) begin
            bad++;
            $display("FAIL rand_disp got=%h want %h,%h,%h,%h",
                     {disp3, disp2, disp1, disp0},
                     mdisp[3], mdisp[2], mdisp[1], mdisp[0]);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_change();
        test_entry();
        test_bounce();
        test_clr();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
